// File: rtl/mure_pkg.sv
`default_nettype none
// ============================================================================
// mure_pkg : shared types for the multi-port itype detector
// Rev 1.0
// ============================================================================
package mure_pkg;

    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    typedef enum logic [3:0] {
        ITYPE_NONE        = 4'd0,
        ITYPE_EXCEPTION   = 4'd1,
        ITYPE_INTERRUPT   = 4'd2,
        ITYPE_ERET        = 4'd3,
        ITYPE_NOT_TAKEN   = 4'd4,
        ITYPE_TAKEN       = 4'd5,
        ITYPE_UNINF       = 4'd6,
        ITYPE_UNINF_CALL  = 4'd8,
        ITYPE_INF_CALL    = 4'd9,
        ITYPE_UNINF_TAIL  = 4'd10,
        ITYPE_INF_TAIL    = 4'd11,
        ITYPE_COSWAP      = 4'd12,
        ITYPE_RETURN      = 4'd13,
        ITYPE_UNINF_JUMP  = 4'd14,
        ITYPE_INF_JUMP    = 4'd15
    } itype_e;

    typedef struct packed {
        cf_t  cf_type;
        logic taken;
    } br_entry_t;

    localparam int c_ITYPE_LEN_EXT = 4;

    function automatic logic itype_ext_en(input int itype_len);
        return itype_len == c_ITYPE_LEN_EXT;
    endfunction

    // Base encoding folds every uninferable jump into 6 and reports inferable jumps as 0.
    function automatic itype_e map_cf(input br_entry_t e, input logic is_call, input logic ext);
        itype_e r;
        r = ITYPE_NONE;
        case (e.cf_type)
            Branch:  r = e.taken ? ITYPE_TAKEN : ITYPE_NOT_TAKEN;
            Jump:    r = ext ? (is_call ? ITYPE_INF_CALL : ITYPE_INF_JUMP) : ITYPE_NONE;
            JumpR:   r = ext ? (is_call ? ITYPE_UNINF_CALL : ITYPE_UNINF_JUMP) : ITYPE_UNINF;
            Return:  r = ext ? ITYPE_RETURN : ITYPE_UNINF;
            default: r = ITYPE_NONE;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/itype_branch_fifo.sv
`default_nettype none
// ============================================================================
// itype_branch_fifo : single-push, multi-pop buffer of resolved branches
// Rev 1.0
// ============================================================================
module itype_branch_fifo
    import mure_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NPOP  = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1,
    localparam int PW   = $clog2(NPOP + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       i_push,
    input  br_entry_t                  i_push_data,
    input  logic [PW-1:0]              i_pop_cnt,
    output br_entry_t [NPOP-1:0]       o_entries,
    output logic [CW-1:0]              o_count,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int MW = (CW > PW) ? CW : PW;

    br_entry_t        r_mem [DEPTH];
    logic [AW-1:0]    r_rp;
    logic [AW-1:0]    r_wp;
    logic [CW-1:0]    r_count;

    logic [MW-1:0]    w_req;
    logic [MW-1:0]    w_cnt;
    logic [MW-1:0]    w_taken;
    logic             w_full;
    logic             w_push_ok;

    assign w_req       = MW'(i_pop_cnt);
    assign w_cnt       = MW'(r_count);
    assign w_full      = (r_count == CW'(DEPTH));
    // A pop of more entries than held drains the buffer rather than wrapping.
    assign w_taken     = (w_req > w_cnt) ? w_cnt : w_req;
    assign w_push_ok   = i_push & (~w_full | (w_req != '0));
    assign o_overflow  = i_push & w_full & (w_req == '0);
    assign o_underflow = (w_req > w_cnt);
    assign o_count     = r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rp    <= '0;
            r_wp    <= '0;
            r_count <= '0;
        end else begin
            r_rp    <= r_rp + AW'(w_taken);
            r_wp    <= r_wp + AW'(w_push_ok);
            r_count <= CW'(w_cnt + MW'(w_push_ok) - w_taken);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok && rst_ni) begin
            r_mem[r_wp] <= i_push_data;
        end
    end

    for (genvar k = 0; k < NPOP; k++) begin : g_rd
        assign o_entries[k] = r_mem[r_rp + AW'(k)];
    end

endmodule
`default_nettype wire

// File: rtl/itype_detector_mp.sv
`default_nettype none
// ============================================================================
// itype_detector_mp : classifies up to NRET retired instructions per cycle
// Rev 1.0
// ============================================================================
module itype_detector_mp
    import mure_pkg::*;
#(
    parameter int NRET          = 2,
    parameter int ITYPE_LEN     = 3,
    parameter int BR_FIFO_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      resolved_branch_valid_i,
    input  cf_t                       resolved_branch_type_i,
    input  logic                      resolved_branch_taken_i,
    input  logic [NRET-1:0]           commit_instr_valid_i,
    input  logic [NRET-1:0]           commit_is_cf_i,
    input  logic [NRET-1:0]           commit_is_call_i,
    input  logic                      commit_ex_valid_i,
    input  logic                      interrupt_i,
    input  logic                      eret_i,
    output logic [NRET-1:0]           valid_o,
    output logic [NRET*ITYPE_LEN-1:0] itype_o,
    output logic                      fifo_empty_o,
    output logic                      overflow_o,
    output logic                      underflow_o
);

    localparam int   CW    = $clog2(BR_FIFO_DEPTH) + 1;
    localparam int   PW    = $clog2(NRET + 1);
    localparam int   MW    = (CW > PW) ? CW : PW;
    localparam logic c_EXT = itype_ext_en(ITYPE_LEN);

    br_entry_t [NRET-1:0]  w_entries;
    logic [CW-1:0]         w_count;
    logic                  w_ovf;
    logic                  w_udf;
    logic [PW-1:0]         w_pop_cnt;
    logic [NRET-1:0]       w_valid;
    logic [3:0]            w_code [NRET];
    logic                  w_suppress;
    br_entry_t             w_sel;

    logic [NRET-1:0]           r_valid;
    logic [NRET*ITYPE_LEN-1:0] r_itype;
    logic                      r_ovf;
    logic                      r_udf;

    itype_branch_fifo #(
        .DEPTH (BR_FIFO_DEPTH),
        .NPOP  (NRET)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_push      (resolved_branch_valid_i && (resolved_branch_type_i != NoCF)),
        .i_push_data ('{cf_type: resolved_branch_type_i, taken: resolved_branch_taken_i}),
        .i_pop_cnt   (w_pop_cnt),
        .o_entries   (w_entries),
        .o_count     (w_count),
        .o_overflow  (w_ovf),
        .o_underflow (w_udf)
    );

    // w_pop_cnt doubles as the rank of the next popping port among older ports.
    always_comb begin
        w_valid    = '0;
        w_pop_cnt  = '0;
        w_suppress = 1'b0;
        w_sel      = '0;
        for (int p = 0; p < NRET; p++) begin
            w_code[p] = ITYPE_NONE;
        end
        for (int p = 0; p < NRET; p++) begin
            if (p == 0 && commit_ex_valid_i) begin
                w_valid[p] = 1'b1;
                w_code[p]  = interrupt_i ? ITYPE_INTERRUPT : ITYPE_EXCEPTION;
                w_suppress = 1'b1;
            end else if (p == 0 && eret_i) begin
                w_valid[p] = 1'b1;
                w_code[p]  = ITYPE_ERET;
            end else if (!w_suppress && commit_instr_valid_i[p]) begin
                w_valid[p] = 1'b1;
                if (commit_is_cf_i[p]) begin
                    if (MW'(w_pop_cnt) < MW'(w_count)) begin
                        for (int k = 0; k < NRET; k++) begin
                            if (PW'(k) == w_pop_cnt) w_sel = w_entries[k];
                        end
                        w_code[p] = map_cf(w_sel, commit_is_call_i[p], c_EXT);
                    end
                    w_pop_cnt = w_pop_cnt + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid <= '0;
            r_itype <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_valid <= w_valid;
            for (int p = 0; p < NRET; p++) begin
                r_itype[p*ITYPE_LEN +: ITYPE_LEN] <= ITYPE_LEN'(w_code[p]);
            end
            r_ovf <= r_ovf | w_ovf;
            r_udf <= r_udf | w_udf;
        end
    end

    assign valid_o      = r_valid;
    assign itype_o      = r_itype;
    assign fifo_empty_o = (w_count == '0);
    assign overflow_o   = r_ovf;
    assign underflow_o  = r_udf;

endmodule
`default_nettype wire

// File: doc/itype_detector_mp.md
Name: itype_detector_mp

Overview:
- Parametrised successor to the single-port combinational itype detector.
- Classifies up to NRET retired instructions per cycle into E-trace itypes, with optional extended (4-bit) itype encoding.
- Resolved-branch info from the branch unit arrives before commit, so it is buffered in an in-order FIFO and consumed when the matching control-flow instruction commits.
- Sits between the CVA6 commit/branch-unit taps and the trace encoder's packet logic; all outputs are registered.

Parameters:
- NRET, 2, number of commit ports (1..4).
- ITYPE_LEN, 3, itype width: 3 = base encoding, 4 = extended call/return encoding.
- BR_FIFO_DEPTH, 4, resolved-branch buffer entries (power of 2, ≥2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- resolved_branch_valid_i  in  1  branch unit resolved a control-flow instruction this cycle.
- resolved_branch_type_i  in  cf_t  NoCF/Branch/Jump/JumpR/Return.
- resolved_branch_taken_i  in  1  taken flag of the resolved instruction.
- commit_instr_valid_i  in  NRET  per-port commit valid; port 0 is oldest.
- commit_is_cf_i  in  NRET  committed instruction went through the branch unit.
- commit_is_call_i  in  NRET  committed jump writes the link register (rd = x1/x5).
- commit_ex_valid_i  in  1  exception or interrupt taken on port 0.
- interrupt_i  in  1  qualifies commit_ex_valid_i as an interrupt.
- eret_i  in  1  port-0 instruction is an xRET.
- valid_o  out  NRET  per-port itype valid.
- itype_o  out  NRET*ITYPE_LEN  per-port itype; port p occupies bits [p*ITYPE_LEN +: ITYPE_LEN].
- fifo_empty_o  out  1  branch FIFO empty.
- overflow_o  out  1  sticky: a push was dropped because the FIFO was full.
- underflow_o  out  1  sticky: a control-flow commit found the FIFO empty.

Behaviour:
- Reset (rst_ni=0 at posedge): valid_o=0, itype_o=0, FIFO pointers and count cleared, fifo_empty_o=1, overflow_o=0, underflow_o=0. Inputs are ignored while in reset.
- Latency: outputs for commit cycle N appear registered in cycle N+1. No combinational path from input to output.
- FIFO push:
  - Push when resolved_branch_valid_i=1 and type≠NoCF; store {type, taken}.
  - Push when full and with no pop in the same cycle: entry is dropped and overflow_o is set.
  - Push and pop in the same cycle while full: legal, no overflow.
- No bypass: a push only becomes visible to pops from the next cycle onward.
- FIFO pop:
  - Pop count = number of ports p with commit_instr_valid_i[p] & commit_is_cf_i[p] that are not suppressed by an exception.
  - Port k consumes the k-th oldest entry among those popping.
  - Pop count > occupancy: ports without an entry output itype 0 (valid still 1), underflow_o is set, and the FIFO is emptied.
- Per-port priority, port 0 only:
  - commit_ex_valid_i: itype 2 if interrupt_i, else 1. All ports p>0 get valid_o[p]=0. No pop occurs.
  - Else eret_i: itype 3, no pop.
- Control-flow mapping for any port with an entry:
  - Branch: taken → 5, not taken → 4.
  - ITYPE_LEN=3: JumpR or Return → 6; Jump → 0 (inferable); entry still consumed.
  - ITYPE_LEN=4:
    - Return → 13.
    - JumpR with call → 8; JumpR without call → 14.
    - Jump with call → 9; Jump without call → 15.
- Otherwise: a valid commit outputs itype 0; an invalid port outputs valid 0 and itype 0.
- Occupancy arithmetic: count width is $clog2(BR_FIFO_DEPTH)+1. Read and write pointers wrap modulo BR_FIFO_DEPTH. New count = count + push_accepted − pops_taken, saturating at 0.
- Sticky flags clear only on reset.

Decomposition:
- Shared package (mure_pkg):
  - itype_e extended to the 4-bit values 0–15 (base values unchanged).
  - br_entry_t {cf_t type; logic taken}.
  - ITYPE_EXT_EN constant helper.
- cf_t is reused from the CVA6 package.
- Sub-module itype_branch_fifo: single push, up to NRET pops per cycle, exposes the NRET oldest entries plus count. Parameters: DEPTH, NPOP.
- Classification stays in the top as an unrolled per-port combinational block feeding the output registers.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles while driving pushes and commits → valid_o=0, itype_o=0, fifo_empty_o=1, both sticky flags 0.
- Single branch: push Branch/taken in cycle 0; commit port 0 with is_cf=1 in cycle 2 → cycle 3 shows valid_o[0]=1, itype_o[0]=5, fifo_empty_o=1.
- Dual retire (NRET=2): push Branch/not-taken, then JumpR; commit both ports with is_cf=1 in one cycle → next cycle port0=4, port1=6, FIFO empty.
- Exception (NRET=2): FIFO holds 1 entry; commit port 0 with commit_ex_valid_i=1, interrupt_i=1, and port 1 valid with is_cf=1 → port0 itype=2, valid_o[1]=0, FIFO count still 1. Repeat with interrupt_i=0 → port0 itype=1.
- FIFO boundaries (BR_FIFO_DEPTH=4):
  - 5 pushes with no pops → overflow_o=1; the next 4 pops return entries 1–4 in order.
  - Push+pop while full → no overflow.
  - Commit a control-flow instruction with the FIFO empty → underflow_o=1, itype 0.
- Extended mode (ITYPE_LEN=4): commits of Return → 13; JumpR+call → 8; Jump without call → 15. Same sequence at ITYPE_LEN=3 → 6, 6, 0, with the FIFO still fully drained.
